// File: rtl/dm_bytelane_mem.sv
// dm_bytelane_mem
//   Data memory for the MEM stage of the pipelined MIPS core. Handles byte,
//   halfword and word loads/stores with sign/zero extension on loads. Misaligned
//   accesses are flagged and suppressed. After reset the array is zeroed by a
//   sequential sweep, one word per clock, while busy is high.
//
// Parameters
//   ADDR_W    word-address width; depth = 2**ADDR_W 32-bit words
//   REG_READ  0: combinational read path, 1: registered read (1-cycle latency)
//   TRACE     1: print every committed store (simulation only)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   addr       in   [31:0] byte address; bits [ADDR_W+1:2] select the word
//   wdata      in   [31:0] right-aligned store data
//   we         in   write request
//   re         in   read request
//   size       in   [1:0] 00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   sign_ext   in   loads: 1 sign-extend, 0 zero-extend
//   rdata      out  [31:0] load result (0 whenever rvalid is low)
//   rvalid     out  rdata is valid
//   busy       out  clear sweep in progress; accesses ignored
//   align_err  out  registered one-cycle pulse for a misaligned access
//   err_addr   out  [31:0] address of the most recent misaligned access
module dm_bytelane_mem #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned REG_READ = 0,
    parameter int unsigned TRACE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        align_err,
    output logic [31:0] err_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word;
    logic [31:0]       merged_word;
    logic [31:0]       lane_data;
    logic [31:0]       lane_mask;
    logic [31:0]       load_val;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic              aligned;
    logic              access;
    logic              fault;
    logic              store;
    logic              load;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_ptr == '1) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------ access decode
    assign widx = addr[ADDR_W+1:2];

    always_comb begin
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign access = (we | re) & ~busy;
    assign fault  = access & ~aligned;
    assign store  = we & aligned & ~busy;
    assign load   = re & aligned & ~busy;

    // ------------------------------------------------------------- store
    // Replicate the right-aligned data across the word and keep only the
    // addressed lanes, so the merge is a single mask operation.
    always_comb begin
        lane_data = wdata;
        lane_mask = '1;
        case (size)
            2'b00: begin
                lane_data = {4{wdata[7:0]}};
                lane_mask = 32'h0000_00FF << {addr[1:0], 3'b000};
            end
            2'b01: begin
                lane_data = {2{wdata[15:0]}};
                lane_mask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: begin
                lane_data = wdata;
                lane_mask = '1;
            end
        endcase
    end

    assign rd_word     = mem[widx];
    assign merged_word = (rd_word & ~lane_mask) | (lane_data & lane_mask);

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (store) begin
            mem[widx] <= merged_word;
        end
    end

    // -------------------------------------------------------------- load
    always_comb begin
        case (addr[1:0])
            2'b00:   load_byte = rd_word[7:0];
            2'b01:   load_byte = rd_word[15:8];
            2'b10:   load_byte = rd_word[23:16];
            default: load_byte = rd_word[31:24];
        endcase
        load_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_val = {{24{sign_ext & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{sign_ext & load_half[15]}}, load_half};
            default: load_val = rd_word;
        endcase
    end

    // rd_word is sampled before the edge that commits a same-cycle store,
    // giving read-first behaviour in both read modes.
    if (REG_READ == 0) begin : g_comb_read
        assign rvalid = load;
        assign rdata  = load ? load_val : '0;
    end else begin : g_reg_read
        logic [31:0] rdata_q;
        logic        rvalid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= load ? load_val : '0;
                rvalid_q <= load;
            end
        end

        assign rvalid = rvalid_q;
        assign rdata  = rdata_q;
    end

    // ------------------------------------------------------ fault report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
            err_addr  <= '0;
        end else begin
            align_err <= fault;
            if (fault) begin
                err_addr <= addr;
            end
        end
    end

    // ------------------------------------------------------------- trace
`ifndef SYNTHESIS
    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (store) begin
                $display("*%h <= %h", {addr[31:2], 2'b00}, merged_word);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_bytelane_mem.sv
module tb_dm_bytelane_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign_ext;

    logic [31:0] rdata0, rdata1, err_addr0, err_addr1;
    logic        rvalid0, rvalid1, busy0, busy1, align_err0, align_err1;

    int tests = 0;
    int fails = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    dm_bytelane_mem #(.ADDR_W(10), .REG_READ(0), .TRACE(1)) u_comb (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .size(size), .sign_ext(sign_ext), .rdata(rdata0), .rvalid(rvalid0),
        .busy(busy0), .align_err(align_err0), .err_addr(err_addr0)
    );

    dm_bytelane_mem #(.ADDR_W(10), .REG_READ(1), .TRACE(0)) u_reg (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .size(size), .sign_ext(sign_ext), .rdata(rdata1), .rvalid(rvalid1),
        .busy(busy1), .align_err(align_err1), .err_addr(err_addr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a DUT presents rvalid.
    always @(negedge clk) begin
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL comb_unexpected_rvalid: got rdata %h expected no read", rdata0);
            end else begin
                chk("comb_rdata", rdata0, q0.pop_front());
            end
        end else begin
            chk("comb_rdata_idle_zero", rdata0, 32'h0);
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL reg_unexpected_rvalid: got rdata %h expected no read", rdata1);
            end else begin
                chk("reg_rdata", rdata1, q1.pop_front());
            end
        end else begin
            chk("reg_rdata_idle_zero", rdata1, 32'h0);
        end
    end

    task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic expv, input logic [31:0] ex);
        @(posedge clk); #1;
        we = w; re = r; size = sz; sign_ext = sx; addr = a; wdata = d;
        if (expv) begin
            q0.push_back(ex);
            q1.push_back(ex);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic fault_chk(input logic [31:0] a);
        idle();
        @(negedge clk);
        chk("align_err_pulse_comb", {31'b0, align_err0}, 32'h1);
        chk("align_err_pulse_reg",  {31'b0, align_err1}, 32'h1);
        chk("err_addr_comb", err_addr0, a);
        chk("err_addr_reg",  err_addr1, a);
        idle();
        @(negedge clk);
        chk("align_err_drop_comb", {31'b0, align_err0}, 32'h0);
        chk("align_err_drop_reg",  {31'b0, align_err1}, 32'h0);
        chk("err_addr_hold_comb", err_addr0, a);
    endtask

    // Counts busy cycles after reset release; optionally drives accesses
    // during the sweep that must all be ignored.
    task automatic wait_sweep(input bit garbage);
        int c0 = 0;
        int c1 = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) break;
            if (busy0) c0++;
            if (busy1) c1++;
            chk("busy_align_err_comb", {31'b0, align_err0}, 32'h0);
            chk("busy_align_err_reg",  {31'b0, align_err1}, 32'h0);
            if (garbage) begin
                if (i < 100) begin
                    we = 1'b1; re = 1'b1; size = 2'b10; addr = 32'h14; wdata = 32'hDEAD_BEEF;
                end else if (i < 200) begin
                    we = 1'b1; re = 1'b1; size = 2'b11; addr = 32'h33;
                end else begin
                    we = 1'b0; re = 1'b0;
                end
            end
        end
        chk("sweep_len_comb", 32'(c0), 32'd1024);
        chk("sweep_len_reg",  32'(c1), 32'd1024);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; size = 2'b10; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_comb", {31'b0, busy0}, 32'h1);
        chk("rst_busy_reg",  {31'b0, busy1}, 32'h1);
        chk("rst_align_err", {31'b0, align_err0}, 32'h0);
        chk("rst_err_addr",  err_addr0, 32'h0);
        chk("rst_rvalid_reg", {31'b0, rvalid1}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_sweep(1'b1);

        // Memory is clean and nothing written while busy stuck.
        op(0, 1, 2'b10, 0, 32'h14, 0, 1, 32'h0000_0000);
        // Word store, then byte / half loads.
        op(1, 0, 2'b10, 0, 32'h10, 32'h1122_3344, 0, 0);
        op(0, 1, 2'b00, 1, 32'h13, 0, 1, 32'h0000_0011);
        op(0, 1, 2'b00, 1, 32'h10, 0, 1, 32'h0000_0044);
        op(0, 1, 2'b01, 1, 32'h12, 0, 1, 32'h0000_1122);
        op(0, 1, 2'b01, 0, 32'h10, 0, 1, 32'h0000_3344);
        // Byte store to lane 1 (upper wdata bits must be ignored).
        op(1, 0, 2'b00, 0, 32'h21, 32'h1234_5680, 0, 0);
        op(0, 1, 2'b00, 1, 32'h21, 0, 1, 32'hFFFF_FF80);
        op(0, 1, 2'b00, 0, 32'h21, 0, 1, 32'h0000_0080);
        op(0, 1, 2'b10, 0, 32'h20, 0, 1, 32'h0000_8000);
        // Half store to upper half.
        op(1, 0, 2'b01, 0, 32'h32, 32'h0000_BEEF, 0, 0);
        op(0, 1, 2'b01, 1, 32'h32, 0, 1, 32'hFFFF_BEEF);
        op(0, 1, 2'b01, 0, 32'h32, 0, 1, 32'h0000_BEEF);
        op(0, 1, 2'b10, 0, 32'h30, 0, 1, 32'hBEEF_0000);
        // Misaligned half store: suppressed and flagged.
        op(1, 0, 2'b01, 0, 32'h33, 32'h0000_1234, 0, 0);
        fault_chk(32'h33);
        op(0, 1, 2'b10, 1, 32'h30, 0, 1, 32'hBEEF_0000);
        // Misaligned word load.
        op(0, 1, 2'b10, 0, 32'h22, 0, 0, 0);
        fault_chk(32'h22);
        // Store/load round trip and read-first on same-cycle access.
        op(1, 0, 2'b10, 0, 32'h40, 32'hA5A5_A5A5, 0, 0);
        op(0, 1, 2'b10, 0, 32'h40, 0, 1, 32'hA5A5_A5A5);
        op(1, 1, 2'b10, 0, 32'h40, 32'h5A5A_5A5A, 1, 32'hA5A5_A5A5);
        op(0, 1, 2'b10, 0, 32'h40, 0, 1, 32'h5A5A_5A5A);
        op(1, 1, 2'b00, 1, 32'h23, 32'h0000_007F, 1, 32'h0000_0000);
        op(0, 1, 2'b00, 1, 32'h23, 0, 1, 32'h0000_007F);
        op(0, 1, 2'b10, 0, 32'h20, 0, 1, 32'h7F00_8000);
        // Reserved size is always misaligned.
        op(0, 1, 2'b11, 0, 32'h41, 0, 0, 0);
        fault_chk(32'h41);
        repeat (3) idle();

        // Full reset, partial sweep, reset again mid-sweep.
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_busy", {31'b0, busy0}, 32'h1);
        chk("rst2_err_addr_comb", err_addr0, 32'h0);
        chk("rst2_err_addr_reg",  err_addr1, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'b0, busy0}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_sweep(1'b0);
        op(0, 1, 2'b10, 0, 32'h10, 0, 1, 32'h0000_0000);
        op(0, 1, 2'b10, 0, 32'h40, 0, 1, 32'h0000_0000);
        repeat (4) idle();

        chk("scoreboard_drained_comb", 32'(q0.size()), 32'h0);
        chk("scoreboard_drained_reg",  32'(q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
